// File: rtl/prom_loader.sv
// Program store with byte-stream loader; holds the core in reset until a program is loaded.
// Optional load checksum stage enabled by defining PROM_CKSUM_EN.
module prom_loader #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               LD_VALID,
  output logic               LD_READY,
  input  logic [7:0]         LD_BYTE,
  input  logic               LD_LAST,
  input  logic               RELOAD,
  input  logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] INSTR,
  output logic               CORE_RSTN,
  output logic               LOADED,
  output logic [PC_W:0]      WORD_CNT,
  output logic               OVF
`ifdef PROM_CKSUM_EN
  ,
  output logic               CK_ERR
`endif
);

  localparam int unsigned NB    = (INSTR_W + 7) / 8;
  localparam int unsigned ASM_W = NB * 8;
  localparam int unsigned BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DEPTH = 2 ** PC_W;
  localparam int unsigned CNT_W = PC_W + 1;

`ifdef PROM_CKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_CHECK, S_ERR} state_t;
`else
  typedef enum logic {S_LOAD, S_RUN} state_t;
`endif

  state_t             state;
  logic [PC_W-1:0]    wr_addr;
  logic [BI_W-1:0]    byte_idx;
  logic [ASM_W-1:0]   asm_q;
  logic [INSTR_W-1:0] mem [DEPTH];
`ifdef PROM_CKSUM_EN
  logic [7:0]         ck_sum;
`endif

  logic               accept_c;
  logic               write_c;
  logic               full_c;
  logic [ASM_W-1:0]   word_c;

`ifdef PROM_CKSUM_EN
  assign LD_READY = RSTN & ((state == S_LOAD) | (state == S_CHECK));
`else
  assign LD_READY = RSTN & (state == S_LOAD);
`endif

  assign accept_c = LD_VALID & LD_READY;
  assign write_c  = accept_c & ~RELOAD & (state == S_LOAD) &
                    (LD_LAST | (byte_idx == BI_W'(NB - 1)));
  assign full_c   = (wr_addr == PC_W'(DEPTH - 1));

  // Merge the incoming byte into its little-endian lane; lanes not yet received stay 0.
  always_comb begin
    word_c = asm_q;
    for (int k = 0; k < int'(NB); k++) begin
      if (byte_idx == BI_W'(k)) word_c[8*k +: 8] = LD_BYTE;
    end
  end

  assign INSTR = (state == S_RUN) ? mem[PC] : '0;

  // Store is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (write_c) mem[wr_addr] <= word_c[INSTR_W-1:0];
  end

  // Reload restarts exactly like reset, so both share one path.
  always_ff @(posedge CLK) begin
    if (!RSTN || RELOAD) begin
      state     <= S_LOAD;
      CORE_RSTN <= 1'b0;
      LOADED    <= 1'b0;
      WORD_CNT  <= '0;
      OVF       <= 1'b0;
      wr_addr   <= '0;
      byte_idx  <= '0;
      asm_q     <= '0;
`ifdef PROM_CKSUM_EN
      ck_sum    <= '0;
      CK_ERR    <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (accept_c) begin
`ifdef PROM_CKSUM_EN
            ck_sum <= 8'(ck_sum + LD_BYTE);
`endif
            if (write_c) begin
              wr_addr  <= wr_addr + PC_W'(1);
              WORD_CNT <= WORD_CNT + CNT_W'(1);
              byte_idx <= '0;
              asm_q    <= '0;
              if (LD_LAST) begin
`ifdef PROM_CKSUM_EN
                state     <= S_CHECK;
`else
                state     <= S_RUN;
                CORE_RSTN <= 1'b1;
                LOADED    <= 1'b1;
`endif
              end else if (full_c) begin
                state     <= S_RUN;
                OVF       <= 1'b1;
                CORE_RSTN <= 1'b1;
                LOADED    <= 1'b1;
              end
            end else begin
              asm_q    <= word_c;
              byte_idx <= byte_idx + BI_W'(1);
            end
          end
        end
`ifdef PROM_CKSUM_EN
        // Check byte must bring the running sum to zero.
        S_CHECK: begin
          if (accept_c) begin
            if (8'(ck_sum + LD_BYTE) == 8'h00) begin
              state     <= S_RUN;
              CORE_RSTN <= 1'b1;
              LOADED    <= 1'b1;
            end else begin
              state  <= S_ERR;
              CK_ERR <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prom_loader.md
Name: prom_loader

Overview:
- Program-memory block directly upstream of the core: owns the instruction store, answers the core's PC with INSTR, and holds the core in reset while a program is loaded.
- Program bytes arrive over a valid/ready byte stream, are assembled little-endian into instruction words, and are written sequentially from address 0.
- On end of load it releases CORE_RSTN, and the core runs from address 0.

Parameters:
- PC_W, 7, PC width; store depth = 2^PC_W words.
- INSTR_W, 8, instruction width; bytes per word NB = ceil(INSTR_W/8).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RSTN  in  1  reset, synchronous and active-low.
- LD_VALID  in  1  byte-stream valid.
- LD_READY  out  1  byte-stream ready.
- LD_BYTE  in  8  program byte.
- LD_LAST  in  1  marks the final program byte; qualified by LD_VALID.
- RELOAD  in  1  one-cycle request to restart loading.
- PC  in  PC_W  instruction address from the core.
- INSTR  out  INSTR_W  instruction to the core.
- CORE_RSTN  out  1  active-low reset to the core.
- LOADED  out  1  program present, core running.
- WORD_CNT  out  PC_W+1  number of words written in the last load.
- OVF  out  1  sticky flag: load filled the store before LAST.

Behaviour:
- States: LOAD, RUN (plus CHECK and ERR with PROM_CKSUM_EN).
- Reset values:
  - state=LOAD, CORE_RSTN=0, LOADED=0, WORD_CNT=0, OVF=0.
  - Byte index=0, write address=0, assembly register=0.
  - Store contents are not reset.
- LD_READY = RSTN & (state==LOAD). It is combinational from state, with no backpressure otherwise.
- A byte is accepted when LD_VALID & LD_READY on a rising edge.
- Byte k of a word (k=0..NB-1) goes to bits [8k+7:8k]. Bits above INSTR_W are dropped.
- Word write happens on the edge that accepts byte NB-1, or the edge that accepts a LAST byte.
  - The store is written at the write address, the address increments, WORD_CNT increments, and the byte index clears.
  - The written word is readable via INSTR from the next cycle.
- LAST accepted mid-word:
  - Unreceived upper bytes are written as 0.
  - The partial word counts in WORD_CNT.
- On the edge accepting LAST: state goes to RUN and CORE_RSTN=1, LOADED=1, registered on that same edge.
- Overflow: if the word at address 2^PC_W-1 is written without LAST:
  - state goes to RUN and OVF=1.
  - WORD_CNT = 2^PC_W.
  - Further bytes are not accepted because LD_READY=0.
- LD_LAST with 0 bytes pending is not a case: LAST always accompanies a byte.
- INSTR:
  - In RUN, INSTR = store[PC], an asynchronous read with zero latency.
  - In any other state, INSTR = 0.
  - Words above WORD_CNT return stale contents.
- RELOAD sampled high:
  - In RUN: state goes to LOAD; CORE_RSTN=0, LOADED=0, WORD_CNT=0, OVF=0; write address and byte index go to 0.
  - In LOAD: RELOAD also restarts the load, dropping any partial word, and has priority over a simultaneously accepted byte, which is discarded.
- RSTN low mid-load: the partial word is lost and the store keeps whatever words were already written. The load restarts from address 0.

Optional Feature:
- Macro PROM_CKSUM_EN.
- When defined:
  - A running 8-bit modular sum of all accepted program bytes is kept; it clears on reset and on RELOAD.
  - On LAST the state goes to CHECK instead of RUN, with LD_READY still 1.
  - The next accepted byte is compared with the two's complement of the sum, so that the sum plus the byte equals 0x00.
  - Match: go to RUN, CORE_RSTN=1, LOADED=1.
  - Mismatch: go to ERR; CORE_RSTN stays 0, LD_READY=0, and output CK_ERR=1. Only RELOAD or RSTN leaves ERR.
  - Overflow skips CHECK and goes directly to RUN.
  - Adds port CK_ERR, out, 1 bit, reset value 0.
- When undefined: no sum, no CHECK/ERR states, no CK_ERR port; behaviour as above.

Test Plan:
- Bench configuration for all cases: PC_W=3, INSTR_W=16.
- After reset, stream 0x34, 0x12, 0x78, 0x56(LAST), with LD_VALID held high -> LD_READY=1 for all 4 bytes. CORE_RSTN and LOADED rise on the 4th edge. WORD_CNT=2. PC=0 gives INSTR=0x1234; PC=1 gives 0x5678.
- Stream 0xAB, 0xCD, 0xEF(LAST) -> word1 = 0x00EF (zero padding), WORD_CNT=2. LD_VALID toggling 1/0 between bytes gives the same result.
- Stream 16 bytes with no LAST -> OVF=1 and LOADED=1 after the 16th byte, WORD_CNT=8. LD_READY=0 afterwards. A 17th byte is not accepted.
- Load done; pulse RELOAD -> next cycle CORE_RSTN=0, LOADED=0, WORD_CNT=0, INSTR=0, LD_READY=1. Reload 0x01, 0x00(LAST) -> INSTR at PC=0 is 0x0001.
- Assert RSTN=0 for 1 cycle after 3 of 4 bytes -> LOADED=0, WORD_CNT=0. Reload from address 0 succeeds.
- PROM_CKSUM_EN:
  - Bytes 0x10, 0x20(LAST), then 0xD0 -> RUN.
  - Repeat with 0xD1 -> CK_ERR=1, CORE_RSTN stays 0, LD_READY=0.
  - RELOAD then clears CK_ERR.
